// File: rtl/channel_demux.sv
// channel_demux: routes one tagged byte stream to alpha/beta/gamma FIFOs (sel=3 broadcasts).
// Latency: a word accepted at edge N is presented on its channel after edge N (1 cycle).
// Backpressure: in_ready drops when a targeted FIFO is full; it never looks at out_ready.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_data word, in_sel route, in_cs chip select
//   out_valid[2:0]      per-channel valid (bit0 alpha, bit1 beta, bit2 gamma)
//   out_ready[2:0]      per-channel consumer ready, same bit order
//   alpha/beta/gamma    channel head words (0 while the channel is empty)
//   drop_count          saturating count of words accepted with in_cs=0
// Optional build macro CHANNEL_DEMUX_STATS_EN adds push_count_alpha/beta/gamma (16-bit, wrapping).

// Small synchronous FIFO used once per channel. head_o is forced to 0 while empty so the
// storage array itself never needs a reset.
module channel_demux_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);

  // Guards are redundant with the top-level handshakes but keep the FIFO safe on its own.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so plain binary increment wraps modulo DEPTH.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A write in the reset cycle is dropped; contents are invisible anyway once count is 0.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

module channel_demux #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_cs,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [WIDTH-1:0] alpha,
  output logic [WIDTH-1:0] beta,
  output logic [WIDTH-1:0] gamma,
  output logic [7:0]       drop_count
`ifdef CHANNEL_DEMUX_STATS_EN
  ,
  output logic [15:0]      push_count_alpha,
  output logic [15:0]      push_count_beta,
  output logic [15:0]      push_count_gamma
`endif
);

  logic [2:0]       sel_hit;
  logic [2:0]       push;
  logic [2:0]       pop;
  logic [2:0]       full;
  logic [2:0]       empty;
  logic [WIDTH-1:0] head [3];
  logic             accept;
  logic [7:0]       drop_q, drop_d;

  // One-hot channel decode; broadcast targets every channel.
  always_comb begin
    sel_hit = 3'b000;
    case (in_sel)
      2'd0:    sel_hit = 3'b001;
      2'd1:    sel_hit = 3'b010;
      2'd2:    sel_hit = 3'b100;
      default: sel_hit = 3'b111;
    endcase
  end

  // Ready only if no targeted channel is full, which makes a broadcast all-or-nothing.
  // Dropped words (cs=0) are always accepted.
  assign in_ready = ~in_cs | ~(|(full & sel_hit));
  assign accept   = in_valid & in_ready;
  assign push     = {3{accept & in_cs}} & sel_hit;

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  for (genvar i = 0; i < 3; i++) begin : g_chan
    channel_demux_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (push[i]),
      .push_dat_i (in_data),
      .pop_i      (pop[i]),
      .full_o     (full[i]),
      .empty_o    (empty[i]),
      .head_o     (head[i])
    );
  end

  assign alpha = head[0];
  assign beta  = head[1];
  assign gamma = head[2];

  // Saturating drop counter.
  always_comb begin
    drop_d = drop_q;
    if (accept && !in_cs && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;

`ifdef CHANNEL_DEMUX_STATS_EN
  logic [15:0] pcnt_q [3];
  logic [15:0] pcnt_d [3];

  // Push counters wrap naturally at 16 bits.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      pcnt_d[i] = pcnt_q[i];
      if (push[i]) pcnt_d[i] = pcnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) pcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) pcnt_q[i] <= pcnt_d[i];
    end
  end

  assign push_count_alpha = pcnt_q[0];
  assign push_count_beta  = pcnt_q[1];
  assign push_count_gamma = pcnt_q[2];
`endif

endmodule

// File: doc/channel_demux.md
Name: channel_demux

Overview:
- Inverse of the team's chip-selected alpha/beta/gamma output mux. Takes one byte stream tagged with sel/cs and routes each word to one of three output channels (alpha, beta, gamma).
- sel=3 broadcasts the word to all three channels.
- Each channel has a small FIFO. Input and outputs use valid/ready handshakes.
- Sits between a single upstream producer and three independent consumers.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, entries per channel FIFO; power of two, ≥2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept the word this cycle.
- in_data  input  WIDTH  upstream word.
- in_sel  input  2  0=alpha, 1=beta, 2=gamma, 3=broadcast to all.
- in_cs  input  1  chip select; 0 = word accepted and discarded.
- out_valid  output  3  per-channel valid; bit0 alpha, bit1 beta, bit2 gamma.
- out_ready  input  3  per-channel consumer ready, same bit order.
- alpha  output  WIDTH  alpha channel head word.
- beta  output  WIDTH  beta channel head word.
- gamma  output  WIDTH  gamma channel head word.
- drop_count  output  8  count of words discarded with cs=0.

Behaviour:
- Reset (synchronous, active-high):
  - Clears all FIFOs to empty and sets out_valid=0.
  - Sets alpha=beta=gamma=0 and drop_count=0.
  - Reset asserted mid-transfer discards all buffered words; an in-flight input handshake in the reset cycle is ignored.
- Accept = in_valid & in_ready, sampled at the rising edge.
- in_ready is combinational from in_cs, in_sel and registered full flags only. It never depends on out_ready, so there is no full-FIFO pass-through.
  - cs=0: in_ready=1.
  - cs=1, sel 0/1/2: in_ready = !full of that channel.
  - cs=1, sel 3: in_ready = all three channels not full. A broadcast is all-or-nothing; no partial writes.
- Push: on accept with cs=1, the word is written to the selected FIFO tail (all three for sel=3).
- Latency: a word accepted at edge N is visible on the channel output with out_valid high after edge N (1 cycle).
- Pop: on out_valid[i] & out_ready[i] at an edge, the channel-i head advances.
- Per-channel occupancy counter, 0..DEPTH, width $clog2(DEPTH)+1.
  - Push only: +1. Pop only: -1. Push and pop in the same cycle: unchanged, with data order preserved.
- full = (count==DEPTH); empty = (count==0).
- Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- out_valid[i] = !empty_i. Channel data output = head entry when non-empty, 0 when empty.
- Channels are fully independent: a stalled channel blocks only inputs targeting it (and broadcasts).
- drop_count increments on each accept with cs=0, saturating at 255. Dropped words never touch any FIFO.
- in_sel and in_data are don't-care when in_valid=0.
- FIFO order is strictly first-in first-out per channel.

Optional Feature:
- Macro CHANNEL_DEMUX_STATS_EN.
- Defined:
  - Adds output ports push_count_alpha, push_count_beta, push_count_gamma, each 16 bits.
  - Each counts words pushed into its FIFO; a broadcast increments all three.
  - Counters wrap 65535→0 and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle → in_ready=1, out_valid=3'b000, alpha=beta=gamma=0, drop_count=0.
- Routing: with out_ready=3'b000, push cs=1 sel=0 data=0x0A, sel=1 data=0x14, sel=2 data=0x1E → one cycle after each accept, alpha=0x0A, beta=0x14, gamma=0x1E, out_valid=3'b111.
- Broadcast: sel=3 data=0x5A, all channels empty → all three outputs 0x5A next cycle; pop alpha only → beta and gamma still 0x5A, out_valid=3'b110.
- Full/backpressure:
  - Push 4 words 0x01..0x04 to beta with out_ready=0 → in_ready=0 for sel=1 and sel=3, in_ready=1 for sel=0.
  - Drain beta → outputs 0x01,0x02,0x03,0x04 in order.
- Simultaneous push/pop on a channel holding 2 words → count stays 2 and order is preserved across pointer wrap over 10 words.
- Drop: 300 accepts with cs=0 → drop_count=255 and all FIFOs stay empty.
- Mid-operation reset: alpha holds 3 words, reset asserted for 1 cycle → out_valid=0, alpha=0.
  - With CHANNEL_DEMUX_STATS_EN defined, push_count_* also return to 0.
